// File: rtl/arbitro_escrita_banco_if.sv
// Writeback request bundle: two requesters (0 = ALU, 1 = memory load)
// sharing the register bank write port through a valid/ack handshake.
interface arbitro_escrita_banco_if #(
    parameter int LARGURA  = 32,
    parameter int ENDERECO = 4
);
    logic                req0;
    logic [ENDERECO-1:0] end0;
    logic [LARGURA-1:0]  dado0;
    logic                ack0;
    logic                req1;
    logic [ENDERECO-1:0] end1;
    logic [LARGURA-1:0]  dado1;
    logic                ack1;

    modport master (
        output req0, end0, dado0, req1, end1, dado1,
        input  ack0, ack1
    );

    modport slave (
        input  req0, end0, dado0, req1, end1, dado1,
        output ack0, ack1
    );
endinterface

// File: rtl/arbitro_escrita_banco.sv
// Round-robin write-port arbiter for the 16x32 register bank, with a
// pending-write scoreboard used by decode for RAW hazard detection.
module arbitro_escrita_banco #(
    parameter int LARGURA  = 32,
    parameter int ENDERECO = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    arbitro_escrita_banco_if.slave   bus,
    input  logic                     reserva,
    input  logic [ENDERECO-1:0]      end_reserva,
    input  logic [ENDERECO-1:0]      consulta_a,
    input  logic [ENDERECO-1:0]      consulta_b,
    output logic                     ocupado_a,
    output logic                     ocupado_b,
    output logic [2**ENDERECO-1:0]   pendente,
    output logic                     Hab_Escrita,
    output logic [ENDERECO-1:0]      Sel_C,
    output logic [LARGURA-1:0]       WC
);
    logic                   prio;
    logic                   grant;
    logic [ENDERECO-1:0]    end_g;
    logic [LARGURA-1:0]     dado_g;
    logic [2**ENDERECO-1:0] pend_next;

    // prio names the requester that wins when both ask; acks are masked during reset
    always_comb begin
        bus.ack0 = 1'b0;
        bus.ack1 = 1'b0;
        if (!reset) begin
            if (bus.req0 && (!bus.req1 || !prio))
                bus.ack0 = 1'b1;
            else if (bus.req1)
                bus.ack1 = 1'b1;
        end
    end

    always_comb begin
        grant  = bus.ack0 | bus.ack1;
        end_g  = bus.ack0 ? bus.end0  : bus.end1;
        dado_g = bus.ack0 ? bus.dado0 : bus.dado1;
    end

    // Set is applied after clear so a same-edge reservation keeps the register pending
    always_comb begin
        pend_next = pendente;
        if (grant)
            pend_next[end_g] = 1'b0;
        if (reserva)
            pend_next[end_reserva] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Hab_Escrita <= 1'b0;
            Sel_C       <= '0;
            WC          <= '0;
            pendente    <= '0;
            prio        <= 1'b0;
        end else begin
            Hab_Escrita <= grant;
            pendente    <= pend_next;
            if (grant) begin
                Sel_C <= end_g;
                WC    <= dado_g;
                prio  <= bus.ack0;
            end
        end
    end

    always_comb begin
        ocupado_a = pendente[consulta_a];
        ocupado_b = pendente[consulta_b];
    end
endmodule

// File: doc/arbitro_escrita_banco.md
# arbitro_escrita_banco

Write-port arbiter and pending-write scoreboard for the 16×32 register bank. It shares the bank's single write port (Hab_Escrita, Sel_C_A, WC) between two writeback sources: requester 0 is the ALU result and requester 1 is the memory load. Sharing uses a valid/ack handshake and round-robin priority. It also tracks which registers have an issued-but-unwritten result, so decode can detect RAW hazards on its two read addresses.

## Interface
- LARGURA, 32, data width of WC/dado ports
- ENDERECO, 4, register address width (2^ENDERECO = 16 registers)

- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- req0  in  1  requester 0 (ALU) has a write pending; held until ack0
- end0  in  ENDERECO  destination register, requester 0
- dado0  in  LARGURA  write data, requester 0
- ack0  out  1  combinational grant to requester 0; the write is accepted at the next posedge
- req1, end1, dado1, ack1  same as above, for requester 1 (memory)
- reserva  in  1  issue stage marks end_reserva as pending-write
- end_reserva  in  ENDERECO  register being reserved
- consulta_a, consulta_b  in  ENDERECO  decode read addresses to check
- ocupado_a, ocupado_b  out  1  combinational: pendente[consulta_x]
- pendente  out  2^ENDERECO  scoreboard vector, registered
- Hab_Escrita  out  1  registered write enable to the bank
- Sel_C  out  ENDERECO  registered write address to the bank
- WC  out  LARGURA  registered write data to the bank

## Operation
- Round-robin pointer prio (1 bit), reset 0.
- Grant logic, combinational:
  - Only req0 high: ack0=1.
  - Only req1 high: ack1=1.
  - Both high: ack goes to requester prio.
  - ack0 and ack1 are never both high.
  - Both acks are 0 while reset is high.
- On a posedge with a grant to requester g:
  - Hab_Escrita<=1, Sel_C<=end_g, WC<=dado_g.
  - prio<=~g.
- On a posedge with no grant:
  - Hab_Escrita<=0; Sel_C and WC hold.
  - prio holds.
- Scoreboard, per posedge:
  - A set applies when reserva=1, to end_reserva.
  - A clear applies when a grant is present, to end_g.
  - Set and clear on the same register in the same edge: set wins. The reservation is younger, so the register stays pending.
  - Reserving an already-pending register keeps the bit at 1. There is no counting, so issue must not reserve a register twice before its write.
  - A write to a non-pending register is legal and leaves pendente unchanged.
- Register 0 is ordinary. There is no hardwired zero.
- Reset values: Hab_Escrita=0, Sel_C=0, WC=0, pendente=0, prio=0, ack0=ack1=0.
- Reset mid-operation discards any in-flight grant. Requesters must re-request after reset deasserts.

## Timing
- Grant latency 0: ack is valid in the same cycle as req.
- Handshake completes at posedge E when req&ack=1.
- The requester may change end/dado or drop req after edge E.
- Hab_Escrita/Sel_C/WC are high/valid from edge E to edge E+1. The bank samples them at the negedge between E and E+1.
- The pendente bit clears at edge E, so ocupado falls in the cycle after E. The data is in the bank by the following negedge.
- Throughput: one write per cycle. Hab_Escrita stays high across back-to-back grants.
- Both requesting continuously gives strict alternation: 0,1,0,1… from reset.
- A loser's req stays high; it is guaranteed a grant within 2 cycles.
- A reservation at edge R makes ocupado visible from edge R on.

## Test plan
- Reset, single write:
  - Stimulus: reset pulse, then req0=1, end0=5, dado0=0xDEADBEEF for one cycle.
  - Response: ack0=1 in that cycle; after the edge, Hab_Escrita=1, Sel_C=5, WC=0xDEADBEEF for one cycle, then Hab_Escrita=0.
- Contention and fairness:
  - Stimulus: req0 and req1 held high 4 cycles, end0=1, end1=2.
  - Response: grants go 0,1,0,1; Sel_C sequence 1,2,1,2; ack0/ack1 never both 1.
- Scoreboard:
  - Stimulus: reserva end_reserva=7; then consulta_a=7 for 3 idle cycles; then req1 end1=7.
  - Response: ocupado_a=1 during the idle cycles; pendente[7]=0 and ocupado_a=0 the cycle after the grant.
- Set/clear collision:
  - Stimulus: register 3 pending; in the same cycle, reserva end_reserva=3 and granted req0 end0=3.
  - Response: pendente[3] remains 1; Hab_Escrita=1, Sel_C=3.
- Reset mid-operation:
  - Stimulus: pendente=0x00F0, req0 high; assert reset asynchronously between edges.
  - Response: pendente=0, Hab_Escrita=0, ack0=0 immediately; after release with req1 and req0 both high, requester 0 is granted first.
- Unreserved write:
  - Stimulus: req1 end1=9 with pendente=0.
  - Response: a normal bank write; pendente stays 0.
